// File: rtl/texture_fetch_arbiter.sv
// Two-port arbiter in front of one synchronous texture memory read port.
// Grants one fetch per clock and steers each read result back to its requester.
module texture_fetch_arbiter #(
  parameter int CHANNEL_BITS = 2,
  parameter int MEM_LATENCY  = 1,
  parameter bit PRIORITY0    = 1'b0
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_r0_valid,
  output logic                      o_r0_ready,
  input  logic                      i_r0_side,
  input  logic [5:0]                i_r0_col,
  input  logic [5:0]                i_r0_row,
  output logic                      o_r0_rvalid,
  output logic [CHANNEL_BITS*3-1:0] o_r0_rdata,
  input  logic                      i_r1_valid,
  output logic                      o_r1_ready,
  input  logic                      i_r1_side,
  input  logic [5:0]                i_r1_col,
  input  logic [5:0]                i_r1_row,
  output logic                      o_r1_rvalid,
  output logic [CHANNEL_BITS*3-1:0] o_r1_rdata,
  output logic                      o_mem_en,
  output logic [12:0]               o_mem_addr,
  input  logic [7:0]                i_mem_data
);

  localparam int TW = CHANNEL_BITS * 3;

  if (MEM_LATENCY < 1 || MEM_LATENCY > 4) begin : g_bad_latency
    $error("texture_fetch_arbiter: MEM_LATENCY must be in 1..4");
  end

  if (TW < 8) begin : g_unused_mem
    logic w_unused_mem;
    assign w_unused_mem = ^i_mem_data[7:TW];
  end

  logic                   r_last_grant;
  logic [MEM_LATENCY-1:0] r_tag_vld;
  logic [MEM_LATENCY-1:0] r_tag_port;
  logic                   w_gnt0;
  logic                   w_gnt1;
  logic                   w_any;
  logic                   w_last_vld;
  logic                   w_last_port;

  // Grants are forced low during reset so every combinational output reads 0.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!i_reset) begin
      if (i_r0_valid && i_r1_valid) begin
        if (PRIORITY0 || r_last_grant) begin
          w_gnt0 = 1'b1;
        end else begin
          w_gnt1 = 1'b1;
        end
      end else begin
        w_gnt0 = i_r0_valid;
        w_gnt1 = i_r1_valid;
      end
    end
  end

  assign w_any      = w_gnt0 | w_gnt1;
  assign o_r0_ready = w_gnt0;
  assign o_r1_ready = w_gnt1;
  assign o_mem_en   = w_any;

  always_comb begin
    o_mem_addr = 13'd0;
    if (w_gnt0) begin
      o_mem_addr = {~i_r0_side, i_r0_col, i_r0_row};
    end else if (w_gnt1) begin
      o_mem_addr = {~i_r1_side, i_r1_col, i_r1_row};
    end
  end

  // Tag pipeline: bit 0 is the newest stage, MSB lines up with returning mem data.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_tag_vld    <= '0;
      r_tag_port   <= '0;
      r_last_grant <= 1'b1;
    end else begin
      r_tag_vld  <= MEM_LATENCY'({r_tag_vld, w_any});
      r_tag_port <= MEM_LATENCY'({r_tag_port, w_gnt1});
      if (w_any) begin
        r_last_grant <= w_gnt1;
      end
    end
  end

  assign w_last_vld  = r_tag_vld[MEM_LATENCY-1];
  assign w_last_port = r_tag_port[MEM_LATENCY-1];
  assign o_r0_rvalid = w_last_vld & ~w_last_port;
  assign o_r1_rvalid = w_last_vld & w_last_port;
  assign o_r0_rdata  = o_r0_rvalid ? i_mem_data[TW-1:0] : '0;
  assign o_r1_rdata  = o_r1_rvalid ? i_mem_data[TW-1:0] : '0;

endmodule

// File: tb/tb_texture_fetch_arbiter.sv
// Directed bench: three arbiter configurations (round-robin lat 1, fixed priority lat 1,
// round-robin lat 3) share one request stimulus, each with its own memory model.
module tb_texture_fetch_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic v0, v1, s0, s1;
  logic [5:0] c0, w0, c1, w1;

  logic        rdy0 [3];
  logic        rdy1 [3];
  logic        rv0  [3];
  logic        rv1  [3];
  logic        men  [3];
  logic [5:0]  rd0  [3];
  logic [5:0]  rd1  [3];
  logic [12:0] maddr[3];
  logic [7:0]  mdat [3];

  logic [12:0] q0, q1;
  logic [12:0] q2 [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Memory contents: byte at address a = a[7:0] ^ {a[12:8], 3'b101}
  function automatic logic [7:0] mem_byte(input logic [12:0] a);
    return a[7:0] ^ {a[12:8], 3'b101};
  endfunction

  always @(posedge clk) begin
    q0    <= maddr[0];
    q1    <= maddr[1];
    q2[0] <= maddr[2];
    q2[1] <= q2[0];
    q2[2] <= q2[1];
  end
  assign mdat[0] = mem_byte(q0);
  assign mdat[1] = mem_byte(q1);
  assign mdat[2] = mem_byte(q2[2]);

  texture_fetch_arbiter #(.CHANNEL_BITS(2), .MEM_LATENCY(1), .PRIORITY0(1'b0)) u_rr (
    .i_clk(clk), .i_reset(rst),
    .i_r0_valid(v0), .o_r0_ready(rdy0[0]), .i_r0_side(s0), .i_r0_col(c0), .i_r0_row(w0),
    .o_r0_rvalid(rv0[0]), .o_r0_rdata(rd0[0]),
    .i_r1_valid(v1), .o_r1_ready(rdy1[0]), .i_r1_side(s1), .i_r1_col(c1), .i_r1_row(w1),
    .o_r1_rvalid(rv1[0]), .o_r1_rdata(rd1[0]),
    .o_mem_en(men[0]), .o_mem_addr(maddr[0]), .i_mem_data(mdat[0]));

  texture_fetch_arbiter #(.CHANNEL_BITS(2), .MEM_LATENCY(1), .PRIORITY0(1'b1)) u_pri (
    .i_clk(clk), .i_reset(rst),
    .i_r0_valid(v0), .o_r0_ready(rdy0[1]), .i_r0_side(s0), .i_r0_col(c0), .i_r0_row(w0),
    .o_r0_rvalid(rv0[1]), .o_r0_rdata(rd0[1]),
    .i_r1_valid(v1), .o_r1_ready(rdy1[1]), .i_r1_side(s1), .i_r1_col(c1), .i_r1_row(w1),
    .o_r1_rvalid(rv1[1]), .o_r1_rdata(rd1[1]),
    .o_mem_en(men[1]), .o_mem_addr(maddr[1]), .i_mem_data(mdat[1]));

  texture_fetch_arbiter #(.CHANNEL_BITS(2), .MEM_LATENCY(3), .PRIORITY0(1'b0)) u_lat3 (
    .i_clk(clk), .i_reset(rst),
    .i_r0_valid(v0), .o_r0_ready(rdy0[2]), .i_r0_side(s0), .i_r0_col(c0), .i_r0_row(w0),
    .o_r0_rvalid(rv0[2]), .o_r0_rdata(rd0[2]),
    .i_r1_valid(v1), .o_r1_ready(rdy1[2]), .i_r1_side(s1), .i_r1_col(c1), .i_r1_row(w1),
    .o_r1_rvalid(rv1[2]), .o_r1_rdata(rd1[2]),
    .o_mem_en(men[2]), .o_mem_addr(maddr[2]), .i_mem_data(mdat[2]));

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    v0 = 1'b0;
    v1 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    v0 = 1'b1; v1 = 1'b1;
    s0 = 1'b0; c0 = 6'd5;  w0 = 6'd9;
    s1 = 1'b1; c1 = 6'd63; w1 = 6'd63;
    repeat (2) @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({rdy0[i], rdy1[i], rv0[i], rv1[i], men[i]} !== 5'b0 ||
          rd0[i] !== 6'd0 || rd1[i] !== 6'd0 || maddr[i] !== 13'd0) begin
        n_fail++;
        $display("FAIL reset_outputs inst=%0d got rdy=%b%b rv=%b%b en=%b rd=%h/%h addr=%h required all 0",
                 i, rdy0[i], rdy1[i], rv0[i], rv1[i], men[i], rd0[i], rd1[i], maddr[i]);
      end
    end
    v0 = 1'b0; v1 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_fetch();
    do_reset();
    @(negedge clk);
    v0 = 1'b1; s0 = 1'b0; c0 = 6'd5; w0 = 6'd9;
    #1;
    n_checks++;
    if (rdy0[0] !== 1'b1 || rdy1[0] !== 1'b0 || men[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL single_grant got rdy0=%b rdy1=%b en=%b required 1 0 1", rdy0[0], rdy1[0], men[0]);
    end
    n_checks++;
    if (maddr[0] !== 13'h1149) begin
      n_fail++;
      $display("FAIL single_addr got %h required 1149", maddr[0]);
    end
    @(posedge clk);
    #1;
    v0 = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rv0[0] !== 1'b1 || rv1[0] !== 1'b0 || rd0[0] !== 6'h04) begin
      n_fail++;
      $display("FAIL single_resp got rv0=%b rv1=%b rd0=%h required 1 0 04", rv0[0], rv1[0], rd0[0]);
    end
    @(negedge clk);
    n_checks++;
    if (rv0[0] !== 1'b0 || rd0[0] !== 6'h00) begin
      n_fail++;
      $display("FAIL single_resp_end got rv0=%b rd0=%h required 0 00", rv0[0], rd0[0]);
    end
  endtask

  // Port 0 addr 0x1042 -> data low bits 0x07; port 1 addr 0x00C4 -> 0x01
  task automatic test_round_robin();
    int cnt0 = 0;
    int cnt1 = 0;
    do_reset();
    s0 = 1'b0; c0 = 6'd1; w0 = 6'd2;
    s1 = 1'b1; c1 = 6'd3; w1 = 6'd4;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      v0 = (i < 6);
      v1 = (i < 6);
      #1;
      if (i < 6) begin
        n_checks++;
        if (rdy0[0] !== (i % 2 == 0) || rdy1[0] !== (i % 2 == 1) || men[0] !== 1'b1) begin
          n_fail++;
          $display("FAIL rr_grant cycle=%0d got rdy0=%b rdy1=%b en=%b required %b %b 1",
                   i, rdy0[0], rdy1[0], men[0], (i % 2 == 0), (i % 2 == 1));
        end
        n_checks++;
        if (maddr[0] !== ((i % 2 == 0) ? 13'h1042 : 13'h00C4)) begin
          n_fail++;
          $display("FAIL rr_addr cycle=%0d got %h", i, maddr[0]);
        end
      end
      if (i >= 1) begin
        n_checks++;
        if (rv0[0] !== (i % 2 == 1) || rv1[0] !== (i % 2 == 0) ||
            rd0[0] !== ((i % 2 == 1) ? 6'h07 : 6'h00) || rd1[0] !== ((i % 2 == 0) ? 6'h01 : 6'h00)) begin
          n_fail++;
          $display("FAIL rr_resp cycle=%0d got rv0=%b rv1=%b rd0=%h rd1=%h", i, rv0[0], rv1[0], rd0[0], rd1[0]);
        end
      end
      if (rv0[0] === 1'b1) cnt0++;
      if (rv1[0] === 1'b1) cnt1++;
    end
    n_checks++;
    if (cnt0 != 3 || cnt1 != 3) begin
      n_fail++;
      $display("FAIL rr_counts got %0d/%0d required 3/3", cnt0, cnt1);
    end
  endtask

  task automatic test_priority();
    do_reset();
    s0 = 1'b0; c0 = 6'd1; w0 = 6'd2;
    s1 = 1'b1; c1 = 6'd3; w1 = 6'd4;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      v0 = 1'b1; v1 = 1'b1;
      #1;
      n_checks++;
      if (rdy0[1] !== 1'b1 || rdy1[1] !== 1'b0 || maddr[1] !== 13'h1042) begin
        n_fail++;
        $display("FAIL pri_grant cycle=%0d got rdy0=%b rdy1=%b addr=%h required 1 0 1042",
                 i, rdy0[1], rdy1[1], maddr[1]);
      end
    end
    @(negedge clk);
    v0 = 1'b0;
    #1;
    n_checks++;
    if (rdy1[1] !== 1'b1 || rdy0[1] !== 1'b0 || maddr[1] !== 13'h00C4) begin
      n_fail++;
      $display("FAIL pri_switch got rdy0=%b rdy1=%b addr=%h required 0 1 00C4", rdy0[1], rdy1[1], maddr[1]);
    end
    n_checks++;
    if (rv0[1] !== 1'b1 || rd0[1] !== 6'h07) begin
      n_fail++;
      $display("FAIL pri_resp got rv0=%b rd0=%h required 1 07", rv0[1], rd0[1]);
    end
    @(negedge clk);
    v1 = 1'b0;
    #1;
    n_checks++;
    if (rv1[1] !== 1'b1 || rd1[1] !== 6'h01) begin
      n_fail++;
      $display("FAIL pri_resp1 got rv1=%b rd1=%h required 1 01", rv1[1], rd1[1]);
    end
  endtask

  // Address 0x0FFF -> data low bits 0x02
  task automatic test_latency3();
    do_reset();
    @(negedge clk);
    v1 = 1'b1; s1 = 1'b1; c1 = 6'd63; w1 = 6'd63;
    #1;
    n_checks++;
    if (rdy1[2] !== 1'b1 || maddr[2] !== 13'h0FFF) begin
      n_fail++;
      $display("FAIL lat3_grant got rdy1=%b addr=%h required 1 0FFF", rdy1[2], maddr[2]);
    end
    @(posedge clk);
    #1;
    v1 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_checks++;
      if (rv1[2] !== (k == 3) || rd1[2] !== ((k == 3) ? 6'h02 : 6'h00) || rv0[2] !== 1'b0) begin
        n_fail++;
        $display("FAIL lat3_resp k=%0d got rv1=%b rd1=%h rv0=%b required %b", k, rv1[2], rd1[2], rv0[2], (k == 3));
      end
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    s0 = 1'b0; c0 = 6'd5;  w0 = 6'd9;
    s1 = 1'b1; c1 = 6'd63; w1 = 6'd63;
    @(negedge clk);
    v0 = 1'b1; v1 = 1'b1;
    #1;
    n_checks++;
    if (rdy0[2] !== 1'b1 || rdy1[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_first_tie got rdy0=%b rdy1=%b required 1 0", rdy0[2], rdy1[2]);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (rdy1[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_second got rdy1=%b required 1", rdy1[2]);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({rdy0[2], rdy1[2], rv0[2], rv1[2], men[2]} !== 5'b0 || maddr[2] !== 13'd0 ||
        rd0[2] !== 6'd0 || rd1[2] !== 6'd0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs got rdy=%b%b rv=%b%b en=%b addr=%h required all 0",
               rdy0[2], rdy1[2], rv0[2], rv1[2], men[2], maddr[2]);
    end
    v0 = 1'b0; v1 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++;
      if (rv0[2] !== 1'b0 || rv1[2] !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_stale k=%0d got rv0=%b rv1=%b required 0 0", k, rv0[2], rv1[2]);
      end
    end
    v0 = 1'b1; v1 = 1'b1;
    #1;
    n_checks++;
    if (rdy0[2] !== 1'b1 || rdy1[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_tie_after got rdy0=%b rdy1=%b required 1 0", rdy0[2], rdy1[2]);
    end
    @(negedge clk);
    v0 = 1'b0; v1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_round_robin();
    test_priority();
    test_latency3();
    test_reset_midflight();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
